// File: rtl/rs_age_ordered_pkg.sv
// Shared defaults and op-type encodings for the age-ordered reservation station.
package rs_age_ordered_pkg;

    localparam int unsigned RS_SIZE_BIT_DEF = 3;
    localparam int unsigned ROB_BIT_DEF     = 4;
    localparam int unsigned TYPE_W_DEF      = 5;
    localparam int unsigned CDB_N_DEF       = 2;
    localparam int unsigned XLEN_DEF        = 32;

    typedef enum logic [TYPE_W_DEF-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_SLL  = 5'd5,
        OP_SRL  = 5'd6,
        OP_SRA  = 5'd7,
        OP_SLT  = 5'd8,
        OP_SLTU = 5'd9,
        OP_BEQ  = 5'd10,
        OP_BNE  = 5'd11,
        OP_BLT  = 5'd12,
        OP_BGE  = 5'd13,
        OP_LUI  = 5'd14,
        OP_JAL  = 5'd15
    } op_type_e;

endpackage

// File: rtl/rs_age_ordered_oldest_select.sv
// Combinational tournament tree: picks the requesting leaf with the smallest
// (key - base) modulo 2^KEY_W; ties go to the lower index.
module rs_oldest_select #(
    parameter int unsigned N_BIT = 3,
    parameter int unsigned KEY_W = 4
) (
    input  logic [(1<<N_BIT)-1:0]            req_i,
    input  logic [(1<<N_BIT)-1:0][KEY_W-1:0] key_i,
    input  logic [KEY_W-1:0]                 base_i,
    output logic                             found_c_o,
    output logic [N_BIT-1:0]                 sel_idx_c_o
);
    localparam int unsigned N     = 1 << N_BIT;
    localparam int unsigned NODES = 2 * N - 1;

    // Heap layout: leaves at N-1.., left subtree always holds the lower indices.
    always_comb begin
        logic             nv   [NODES];
        logic [KEY_W-1:0] nage [NODES];
        logic [N_BIT-1:0] nidx [NODES];
        for (int n = 0; n < NODES; n++) begin
            nv[n]   = 1'b0;
            nage[n] = '0;
            nidx[n] = '0;
        end
        for (int i = 0; i < N; i++) begin
            nv[N-1+i]   = req_i[i];
            nage[N-1+i] = KEY_W'(key_i[i] - base_i);
            nidx[N-1+i] = N_BIT'(i);
        end
        for (int n = N - 2; n >= 0; n--) begin
            if (nv[2*n+1] && (!nv[2*n+2] || nage[2*n+1] <= nage[2*n+2])) begin
                nage[n] = nage[2*n+1];
                nidx[n] = nidx[2*n+1];
            end else begin
                nage[n] = nage[2*n+2];
                nidx[n] = nidx[2*n+2];
            end
            nv[n] = nv[2*n+1] | nv[2*n+2];
        end
        found_c_o   = nv[0];
        sel_idx_c_o = nidx[0];
    end

endmodule

// File: rtl/rs_age_ordered.sv
// Reservation station for one ALU: CDB wakeup, oldest-ready issue relative to
// the ROB head into a registered slot with back-pressure, and flush.
module rs_age_ordered
    import rs_age_ordered_pkg::*;
#(
    parameter int unsigned RS_SIZE_BIT = RS_SIZE_BIT_DEF,
    parameter int unsigned ROB_BIT     = ROB_BIT_DEF,
    parameter int unsigned TYPE_W      = TYPE_W_DEF,
    parameter int unsigned CDB_N       = CDB_N_DEF,
    parameter int unsigned XLEN        = XLEN_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic [ROB_BIT-1:0]       rob_head,
    input  logic                     disp_valid,
    input  logic [ROB_BIT-1:0]       disp_rob_id,
    input  logic [TYPE_W-1:0]        disp_type,
    input  logic [XLEN-1:0]          disp_v1,
    input  logic [XLEN-1:0]          disp_v2,
    input  logic                     disp_has_dep1,
    input  logic                     disp_has_dep2,
    input  logic [ROB_BIT-1:0]       disp_dep1,
    input  logic [ROB_BIT-1:0]       disp_dep2,
    output logic                     rs_full,
    output logic [RS_SIZE_BIT:0]     rs_count,
    input  logic [CDB_N-1:0]         cdb_valid,
    input  logic [CDB_N*ROB_BIT-1:0] cdb_rob_id,
    input  logic [CDB_N*XLEN-1:0]    cdb_value,
    output logic                     issue_valid,
    output logic [XLEN-1:0]          issue_v1,
    output logic [XLEN-1:0]          issue_v2,
    output logic [ROB_BIT-1:0]       issue_rob_id,
    output logic [TYPE_W-1:0]        issue_type,
    input  logic                     issue_accept
);
    localparam int unsigned RS_SIZE = 1 << RS_SIZE_BIT;
    localparam int unsigned CNT_W   = RS_SIZE_BIT + 1;

    typedef struct packed {
        logic               busy;
        logic [ROB_BIT-1:0] rob_id;
        logic [TYPE_W-1:0]  op;
        logic               has_dep1;
        logic [ROB_BIT-1:0] dep1;
        logic [XLEN-1:0]    v1;
        logic               has_dep2;
        logic [ROB_BIT-1:0] dep2;
        logic [XLEN-1:0]    v2;
    } entry_t;

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];
    entry_t new_ent;

    logic               issue_valid_q, issue_valid_d;
    logic [XLEN-1:0]    issue_v1_q, issue_v1_d;
    logic [XLEN-1:0]    issue_v2_q, issue_v2_d;
    logic [ROB_BIT-1:0] issue_rob_q, issue_rob_d;
    logic [TYPE_W-1:0]  issue_type_q, issue_type_d;
    logic [CNT_W-1:0]   rs_count_q, rs_count_d;
    logic               rs_full_q, rs_full_d;

    logic [RS_SIZE-1:0]                  ready_vec;
    logic [RS_SIZE-1:0]                  free_vec;
    logic [RS_SIZE-1:0][ROB_BIT-1:0]     rob_vec;
    logic [RS_SIZE-1:0][RS_SIZE_BIT-1:0] idx_vec;
    logic                                sel_found, free_found;
    logic [RS_SIZE_BIT-1:0]              sel_idx, free_idx;
    logic                                load, move, disp_ok;

    // Readiness is taken from registered state only.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = ent_q[i].busy && !ent_q[i].has_dep1 && !ent_q[i].has_dep2;
            free_vec[i]  = !ent_q[i].busy;
            rob_vec[i]   = ent_q[i].rob_id;
            idx_vec[i]   = RS_SIZE_BIT'(i);
        end
    end

    rs_oldest_select #(.N_BIT(RS_SIZE_BIT), .KEY_W(ROB_BIT)) u_age_sel (
        .req_i       (ready_vec),
        .key_i       (rob_vec),
        .base_i      (rob_head),
        .found_c_o   (sel_found),
        .sel_idx_c_o (sel_idx)
    );

    // Keys equal to the index with zero base give a plain lowest-free search.
    rs_oldest_select #(.N_BIT(RS_SIZE_BIT), .KEY_W(RS_SIZE_BIT)) u_free_sel (
        .req_i       (free_vec),
        .key_i       (idx_vec),
        .base_i      ('0),
        .found_c_o   (free_found),
        .sel_idx_c_o (free_idx)
    );

    assign load    = !issue_valid_q || issue_accept;
    assign move    = load && sel_found;
    assign disp_ok = disp_valid && !rs_full_q && free_found;

    always_comb begin
        ent_d         = ent_q;
        new_ent       = '0;
        issue_valid_d = issue_valid_q;
        issue_v1_d    = issue_v1_q;
        issue_v2_d    = issue_v2_q;
        issue_rob_d   = issue_rob_q;
        issue_type_d  = issue_type_q;

        // Descending scan so the lowest matching channel overrides the rest.
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int k = CDB_N - 1; k >= 0; k--) begin
                if (ent_q[i].busy && cdb_valid[k]) begin
                    if (ent_q[i].has_dep1 && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == ent_q[i].dep1) begin
                        ent_d[i].has_dep1 = 1'b0;
                        ent_d[i].v1       = cdb_value[k*XLEN +: XLEN];
                    end
                    if (ent_q[i].has_dep2 && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == ent_q[i].dep2) begin
                        ent_d[i].has_dep2 = 1'b0;
                        ent_d[i].v2       = cdb_value[k*XLEN +: XLEN];
                    end
                end
            end
        end

        if (load) begin
            issue_valid_d = sel_found;
            if (sel_found) begin
                issue_v1_d             = ent_q[sel_idx].v1;
                issue_v2_d             = ent_q[sel_idx].v2;
                issue_rob_d            = ent_q[sel_idx].rob_id;
                issue_type_d           = ent_q[sel_idx].op;
                ent_d[sel_idx].busy    = 1'b0;
            end
        end

        new_ent.busy     = 1'b1;
        new_ent.rob_id   = disp_rob_id;
        new_ent.op       = disp_type;
        new_ent.has_dep1 = disp_has_dep1;
        new_ent.dep1     = disp_dep1;
        new_ent.v1       = disp_v1;
        new_ent.has_dep2 = disp_has_dep2;
        new_ent.dep2     = disp_dep2;
        new_ent.v2       = disp_v2;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (cdb_valid[k]) begin
                if (disp_has_dep1 && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == disp_dep1) begin
                    new_ent.has_dep1 = 1'b0;
                    new_ent.v1       = cdb_value[k*XLEN +: XLEN];
                end
                if (disp_has_dep2 && cdb_rob_id[k*ROB_BIT +: ROB_BIT] == disp_dep2) begin
                    new_ent.has_dep2 = 1'b0;
                    new_ent.v2       = cdb_value[k*XLEN +: XLEN];
                end
            end
        end
        if (disp_ok) begin
            ent_d[free_idx] = new_ent;
        end

        rs_count_d = rs_count_q + CNT_W'(disp_ok) - CNT_W'(move);
        rs_full_d  = (rs_count_d == CNT_W'(RS_SIZE));

        if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_d[i].busy = 1'b0;
            end
            issue_valid_d = 1'b0;
            rs_count_d    = '0;
            rs_full_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_v1_q    <= '0;
            issue_v2_q    <= '0;
            issue_rob_q   <= '0;
            issue_type_q  <= '0;
            rs_count_q    <= '0;
            rs_full_q     <= 1'b0;
        end else if (rdy) begin
            ent_q         <= ent_d;
            issue_valid_q <= issue_valid_d;
            issue_v1_q    <= issue_v1_d;
            issue_v2_q    <= issue_v2_d;
            issue_rob_q   <= issue_rob_d;
            issue_type_q  <= issue_type_d;
            rs_count_q    <= rs_count_d;
            rs_full_q     <= rs_full_d;
        end
    end

    assign rs_full      = rs_full_q;
    assign rs_count     = rs_count_q;
    assign issue_valid  = issue_valid_q;
    assign issue_v1     = issue_v1_q;
    assign issue_v2     = issue_v2_q;
    assign issue_rob_id = issue_rob_q;
    assign issue_type   = issue_type_q;

endmodule

// File: tb/tb_rs_age_ordered.sv
// Bench for rs_age_ordered: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a slot-array reference model.
module tb_rs_age_ordered;

    logic        clk;
    logic        rst, rdy, flush;
    logic [3:0]  rob_head;
    logic        disp_valid;
    logic [3:0]  disp_rob_id;
    logic [4:0]  disp_type;
    logic [31:0] disp_v1, disp_v2;
    logic        disp_has_dep1, disp_has_dep2;
    logic [3:0]  disp_dep1, disp_dep2;
    logic        rs_full;
    logic [3:0]  rs_count;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob_id;
    logic [63:0] cdb_value;
    logic        issue_valid;
    logic [31:0] issue_v1, issue_v2;
    logic [3:0]  issue_rob_id;
    logic [4:0]  issue_type;
    logic        issue_accept;

    int checks   = 0;
    int failures = 0;

    // Reference model state: one record per station slot plus the issue slot.
    bit          m_busy [8];
    logic [3:0]  m_rob  [8];
    logic [4:0]  m_type [8];
    bit          m_h1   [8];
    bit          m_h2   [8];
    logic [3:0]  m_d1   [8];
    logic [3:0]  m_d2   [8];
    logic [31:0] m_v1   [8];
    logic [31:0] m_v2   [8];
    bit          m_iv;
    logic [3:0]  m_irob;
    logic [4:0]  m_itype;
    logic [31:0] m_iv1, m_iv2;
    bit          m_full;

    rs_age_ordered dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .flush         (flush),
        .rob_head      (rob_head),
        .disp_valid    (disp_valid),
        .disp_rob_id   (disp_rob_id),
        .disp_type     (disp_type),
        .disp_v1       (disp_v1),
        .disp_v2       (disp_v2),
        .disp_has_dep1 (disp_has_dep1),
        .disp_has_dep2 (disp_has_dep2),
        .disp_dep1     (disp_dep1),
        .disp_dep2     (disp_dep2),
        .rs_full       (rs_full),
        .rs_count      (rs_count),
        .cdb_valid     (cdb_valid),
        .cdb_rob_id    (cdb_rob_id),
        .cdb_value     (cdb_value),
        .issue_valid   (issue_valid),
        .issue_v1      (issue_v1),
        .issue_v2      (issue_v2),
        .issue_rob_id  (issue_rob_id),
        .issue_type    (issue_type),
        .issue_accept  (issue_accept)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cdb_hit(input logic [3:0] tag, output logic [31:0] val);
        val = '0;
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k] && cdb_rob_id[k*4 +: 4] == tag) begin
                val = cdb_value[k*32 +: 32];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 8; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    task automatic model_step();
        int best, bage, a, fr;
        bit do_disp;
        logic [31:0] val;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_busy[i] = 0;
            m_iv = 0; m_irob = '0; m_itype = '0; m_iv1 = '0; m_iv2 = '0; m_full = 0;
        end else if (!rdy) begin
            // frozen
        end else if (flush) begin
            for (int i = 0; i < 8; i++) m_busy[i] = 0;
            m_iv = 0; m_full = 0;
        end else begin
            best = -1; bage = 0; fr = -1;
            for (int i = 0; i < 8; i++) begin
                if (m_busy[i] && !m_h1[i] && !m_h2[i]) begin
                    a = (int'(m_rob[i]) - int'(rob_head) + 16) % 16;
                    if (best < 0 || a < bage) begin best = i; bage = a; end
                end
                if (!m_busy[i] && fr < 0) fr = i;
            end
            do_disp = disp_valid && !m_full && fr >= 0;
            for (int i = 0; i < 8; i++) begin
                if (m_busy[i] && m_h1[i] && cdb_hit(m_d1[i], val)) begin m_h1[i] = 0; m_v1[i] = val; end
                if (m_busy[i] && m_h2[i] && cdb_hit(m_d2[i], val)) begin m_h2[i] = 0; m_v2[i] = val; end
            end
            if (!m_iv || issue_accept) begin
                if (best >= 0) begin
                    m_iv = 1; m_irob = m_rob[best]; m_itype = m_type[best];
                    m_iv1 = m_v1[best]; m_iv2 = m_v2[best]; m_busy[best] = 0;
                end else begin
                    m_iv = 0;
                end
            end
            if (do_disp) begin
                m_busy[fr] = 1; m_rob[fr] = disp_rob_id; m_type[fr] = disp_type;
                m_h1[fr] = disp_has_dep1; m_d1[fr] = disp_dep1; m_v1[fr] = disp_v1;
                m_h2[fr] = disp_has_dep2; m_d2[fr] = disp_dep2; m_v2[fr] = disp_v2;
                if (disp_has_dep1 && cdb_hit(disp_dep1, val)) begin m_h1[fr] = 0; m_v1[fr] = val; end
                if (disp_has_dep2 && cdb_hit(disp_dep2, val)) begin m_h2[fr] = 0; m_v2[fr] = val; end
            end
            m_full = (model_count() == 8);
        end
    endtask

    task automatic compare();
        chk("issue_valid", 32'(issue_valid), 32'(m_iv));
        if (m_iv) begin
            chk("issue_rob_id", 32'(issue_rob_id), 32'(m_irob));
            chk("issue_type", 32'(issue_type), 32'(m_itype));
            chk("issue_v1", issue_v1, m_iv1);
            chk("issue_v2", issue_v2, m_iv2);
        end
        chk("rs_count", 32'(rs_count), 32'(model_count()));
        chk("rs_full", 32'(rs_full), 32'(m_full));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic set_disp(input logic [3:0] tag, input logic [31:0] v1, input logic [31:0] v2,
                            input bit h1, input logic [3:0] d1, input bit h2, input logic [3:0] d2);
        disp_valid = 1; disp_rob_id = tag; disp_type = 5'(tag + 4'd1);
        disp_v1 = v1; disp_v2 = v2;
        disp_has_dep1 = h1; disp_dep1 = d1; disp_has_dep2 = h2; disp_dep2 = d2;
    endtask

    task automatic idle();
        disp_valid = 0; cdb_valid = 2'b00;
    endtask

    initial begin
        rst = 1; rdy = 1; flush = 0; rob_head = '0; issue_accept = 0;
        disp_valid = 0; disp_rob_id = '0; disp_type = '0; disp_v1 = '0; disp_v2 = '0;
        disp_has_dep1 = 0; disp_has_dep2 = 0; disp_dep1 = '0; disp_dep2 = '0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
        tick(); tick();
        chk("reset_issue_valid", 32'(issue_valid), 32'd0);
        chk("reset_issue_v1", issue_v1, 32'd0);
        chk("reset_issue_rob", 32'(issue_rob_id), 32'd0);
        chk("reset_count", 32'(rs_count), 32'd0);
        rst = 0;

        // Simple ready op: two-cycle dispatch-to-issue latency.
        issue_accept = 1;
        set_disp(4'd5, 32'd3, 32'd4, 0, 4'd0, 0, 4'd0);
        tick();
        chk("t1_count_after_disp", 32'(rs_count), 32'd1);
        chk("t1_not_yet_valid", 32'(issue_valid), 32'd0);
        idle(); tick();
        chk("t1_valid", 32'(issue_valid), 32'd1);
        chk("t1_v1", issue_v1, 32'd3);
        chk("t1_v2", issue_v2, 32'd4);
        chk("t1_rob", 32'(issue_rob_id), 32'd5);
        chk("t1_count_zero", 32'(rs_count), 32'd0);
        tick();

        // Wakeup on CDB channel 1.
        set_disp(4'd2, 32'd0, 32'd9, 1, 4'd7, 0, 4'd0);
        tick(); idle(); tick(); tick();
        cdb_valid = 2'b10; cdb_rob_id = {4'd7, 4'd0}; cdb_value = {32'hDEAD, 32'h0};
        tick();
        chk("t2_not_yet_valid", 32'(issue_valid), 32'd0);
        idle(); tick();
        chk("t2_valid", 32'(issue_valid), 32'd1);
        chk("t2_v1", issue_v1, 32'hDEAD);
        chk("t2_rob", 32'(issue_rob_id), 32'd2);
        tick();

        // Same-cycle bypass at dispatch.
        set_disp(4'd3, 32'h22, 32'd0, 0, 4'd0, 1, 4'd9);
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd9}; cdb_value = {32'h0, 32'h11};
        tick(); idle(); tick();
        chk("t3_valid", 32'(issue_valid), 32'd1);
        chk("t3_v2", issue_v2, 32'h11);
        chk("t3_rob", 32'(issue_rob_id), 32'd3);
        tick();

        // Age ordering across the ROB wrap point.
        rob_head = 4'd14; issue_accept = 0;
        set_disp(4'd1, 32'd1, 32'd1, 1, 4'd10, 0, 4'd0); tick();
        set_disp(4'd15, 32'd2, 32'd2, 1, 4'd10, 0, 4'd0); tick();
        set_disp(4'd14, 32'd3, 32'd3, 1, 4'd10, 0, 4'd0); tick();
        idle(); cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd10}; cdb_value = {32'h0, 32'h55};
        tick();
        idle(); issue_accept = 1;
        tick(); chk("t4_first", 32'(issue_rob_id), 32'd14);
        tick(); chk("t4_second", 32'(issue_rob_id), 32'd15);
        tick(); chk("t4_third", 32'(issue_rob_id), 32'd1);
        chk("t4_third_v1", issue_v1, 32'h55);
        tick(); chk("t4_drained", 32'(issue_valid), 32'd0);

        // Fill under stall; the tenth dispatch hits a full station.
        rob_head = 4'd0; issue_accept = 0;
        for (int j = 0; j < 10; j++) begin
            set_disp(4'(j), 32'(j), 32'(j + 100), 0, 4'd0, 0, 4'd0);
            tick();
            if (j == 8) begin
                chk("t5_full", 32'(rs_full), 32'd1);
                chk("t5_count8", 32'(rs_count), 32'd8);
            end
        end
        chk("t5_count_after_extra", 32'(rs_count), 32'd8);
        idle(); issue_accept = 1;
        tick();
        chk("t5_count7", 32'(rs_count), 32'd7);
        chk("t5_not_full", 32'(rs_full), 32'd0);
        chk("t5_next_rob", 32'(issue_rob_id), 32'd1);

        // Flush with a populated station and a competing dispatch.
        tick(); tick();
        chk("t6_count5", 32'(rs_count), 32'd5);
        issue_accept = 0; flush = 1;
        set_disp(4'd12, 32'd7, 32'd7, 0, 4'd0, 0, 4'd0);
        tick();
        chk("t6_count", 32'(rs_count), 32'd0);
        chk("t6_valid", 32'(issue_valid), 32'd0);
        chk("t6_full", 32'(rs_full), 32'd0);
        flush = 0; idle();
        cdb_valid = 2'b11; cdb_rob_id = {4'd4, 4'd3}; cdb_value = {32'h44, 32'h33};
        tick(); tick();
        chk("t6_no_issue", 32'(issue_valid), 32'd0);
        idle();

        // Randomized traffic, every cycle checked against the model.
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 799) == 0);
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 15) == 0) rob_head = 4'($urandom);
            issue_accept  = ($urandom_range(0, 9) < 6);
            disp_valid    = (!m_full || $urandom_range(0, 19) == 0) && ($urandom_range(0, 9) < 6);
            disp_rob_id   = 4'($urandom);
            disp_type     = 5'($urandom);
            disp_v1       = $urandom;
            disp_v2       = $urandom;
            disp_has_dep1 = 1'($urandom);
            disp_has_dep2 = 1'($urandom);
            disp_dep1     = 4'($urandom_range(0, 3));
            disp_dep2     = 4'($urandom_range(0, 3));
            cdb_valid     = 2'($urandom);
            cdb_rob_id    = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            cdb_value     = {$urandom, $urandom};
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_age_ordered.md
Name: rs_age_ordered

Overview:
Parametrised reservation station for the out-of-order core. It sits between the decoder/dispatch stage and one ALU. It holds dispatched operations until both operands are valid, snooping CDB_N broadcast channels (ALU, LSB, future units). Unlike the previous generation, it issues the oldest ready entry relative to the ROB head, drives a registered issue slot with stall back-pressure, and supports a pipeline flush.

Parameters:
RS_SIZE_BIT, 3, log2 of entry count (RS_SIZE = 1<<RS_SIZE_BIT)
ROB_BIT, 4, ROB tag width
TYPE_W, 5, operation type width
CDB_N, 2, number of broadcast (writeback) channels
XLEN, 32, operand width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
flush  in  1  mispredict flush; clears station
rob_head  in  ROB_BIT  tag of the oldest in-flight ROB entry
disp_valid  in  1  dispatch request
disp_rob_id  in  ROB_BIT  destination tag
disp_type  in  TYPE_W  op type
disp_v1, disp_v2  in  XLEN  operand values, valid when the matching has_dep bit is 0
disp_has_dep1, disp_has_dep2  in  1  operand pending
disp_dep1, disp_dep2  in  ROB_BIT  producer tags
rs_full  out  1  registered; no dispatch accepted next cycle
rs_count  out  RS_SIZE_BIT+1  registered occupied-entry count
cdb_valid  in  CDB_N  per-channel broadcast valid
cdb_rob_id  in  CDB_N*ROB_BIT  flattened tags, channel k at [k*ROB_BIT +: ROB_BIT]
cdb_value  in  CDB_N*XLEN  flattened values
issue_valid  out  1  issue slot holds an op
issue_v1, issue_v2  out  XLEN  operands
issue_rob_id  out  ROB_BIT  tag
issue_type  out  TYPE_W  op type
issue_accept  in  1  ALU consumes the slot this cycle

Behaviour:
- Reset (rst=1 at posedge, regardless of rdy): all busy=0; issue_valid=0; issue_v1, issue_v2, issue_rob_id and issue_type=0; rs_full=0; rs_count=0.
- rdy=0: no state change; outputs hold.
- Priority: rst > flush > normal. On flush (with rdy=1): all entries freed, issue_valid<=0, rs_count<=0, rs_full<=0; same-cycle dispatch and CDB updates are discarded.
- Dispatch: if disp_valid and !rs_full, write into the lowest-index free entry. Each operand with has_dep=1 is checked against all CDB channels in the same cycle. On a tag match, the value is captured and has_dep<=0; the lowest channel index wins on multiple matches. disp_valid with rs_full=1 is ignored (protocol error, flagged by a bench assertion).
- Wakeup: each busy entry with has_depX=1 captures cdb_value[k] when cdb_valid[k] and cdb_rob_id[k]==depX. Lowest k wins.
- Ready: busy && !has_dep1 && !has_dep2, evaluated from registered state only. A newly dispatched or newly woken entry is first eligible the following cycle, so the minimum dispatch-to-issue_valid latency is 2 cycles.
- Select: among ready entries, pick the minimum age = (rob_id - rob_head) mod 2^ROB_BIT. On equal age, the lower index wins.
- Issue slot: the slot is loadable when issue_valid==0 or issue_accept==1.
  - If loadable and a ready entry exists: copy the selected entry into the slot, issue_valid<=1, and free the entry in the same edge.
  - If loadable and nothing is ready: issue_valid<=0.
  - If not loadable: the slot holds, and entries are not freed.
- issue_accept while issue_valid=0 is ignored.
- Count: next_count = count + dispatched - moved_to_slot. rs_full <= (next_count == RS_SIZE). rs_count <= next_count.
- A freed entry may be reused by dispatch in the next cycle, not the same cycle.
- The slot contents are not counted in rs_count.

Decomposition:
- Shared package/const.v: RS_SIZE_BIT, ROB_BIT, TYPE_W and CDB_N defaults; the op-type encodings; the rs entry struct fields.
- Sub-module rs_oldest_select: combinational tournament tree over RS_SIZE entries. Inputs: ready vector, rob_id array, rob_head. Outputs: found and sel_idx. Also reused for the lowest-free search with age forced to index.

Test Plan:
1. Dispatch tag 5 (no deps, v1=3, v2=4), head=0, issue_accept=1 → issue_valid=1 two cycles later with v1=3, v2=4, rob_id=5; rs_count returns to 0.
2. Dispatch tag 2 with dep1=7 pending; 3 cycles later cdb channel 1 broadcasts (7, 0xDEAD) → entry wakes; issue_valid next-next cycle with v1=0xDEAD.
3. Same-cycle bypass: dispatch dep2=9 while cdb0=(9, 0x11) → entry stored ready; issues with v2=0x11 with no further broadcast.
4. Age order: head=14; entries tags 1, 15, 14 ready simultaneously → issue order 14, 15, 1 across 3 accepted cycles.
5. Stall/full (RS_SIZE=8): issue_accept=0, 9 dispatches of ready ops → slot takes 1 op; rs_full=1 when rs_count=8; the 10th dispatch is ignored; issue_accept=1 for one cycle → rs_count=7, rs_full=0.
6. Flush with 5 entries and issue_valid=1, plus simultaneous dispatch → next cycle rs_count=0, issue_valid=0, rs_full=0; later CDB broadcasts produce no issue.
